// File: rtl/rect_pkg.sv
// Shared types, screen constants and FSM state encoding for the
// rectangle fill engine (coord_t, dim_t, ext_t, rect_state_t).
package rect_pkg;

  localparam int COORD_W  = 11;
  localparam int DIM_W    = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic        [DIM_W-1:0]   dim_t;
  // One extra bit so x+w never overflows.
  typedef logic signed [COORD_W:0]   ext_t;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    DRAW,
    DONE
  } rect_state_t;

  function automatic ext_t sx(coord_t v);
    return ext_t'({v[COORD_W-1], v});
  endfunction

  function automatic ext_t zx(dim_t v);
    return ext_t'({{(COORD_W+1-DIM_W){1'b0}}, v});
  endfunction

endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle to the screen.
// Ports: i_x/i_y/i_w/i_h request; o_*_lo/o_*_hi inclusive bounds, o_empty.
module rect_clip
  import rect_pkg::*;
(
  input  coord_t     i_x,
  input  coord_t     i_y,
  input  dim_t       i_w,
  input  dim_t       i_h,
  output ext_t       o_x_lo,
  output ext_t       o_x_hi,
  output ext_t       o_y_lo,
  output ext_t       o_y_hi,
  output logic       o_empty
);

  localparam ext_t SW  = ext_t'(SCREEN_W);
  localparam ext_t SH  = ext_t'(SCREEN_H);
  localparam ext_t ONE = ext_t'(1);

  ext_t w_x;
  ext_t w_y;
  ext_t w_x_end;
  ext_t w_y_end;

  always_comb begin
    w_x     = sx(i_x);
    w_y     = sx(i_y);
    w_x_end = w_x + zx(i_w);
    w_y_end = w_y + zx(i_h);
    o_x_lo  = w_x[COORD_W] ? '0 : w_x;
    o_y_lo  = w_y[COORD_W] ? '0 : w_y;
    o_x_hi  = ((w_x_end < SW) ? w_x_end : SW) - ONE;
    o_y_hi  = ((w_y_end < SH) ? w_y_end : SH) - ONE;
    o_empty = (i_w == '0) || (i_h == '0) ||
              (o_x_lo > o_x_hi) || (o_y_lo > o_y_hi);
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Clips a rectangle request and emits one pixel write per clock,
// row-major. Ports: req_* handshake/fields, x/y/white/wr_en write
// path, busy/done status. RECT_FILL_OUTLINE_EN adds req_outline.
module rect_fill_engine
  import rect_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_valid,
  output logic   req_ready,
  input  coord_t req_x,
  input  coord_t req_y,
  input  dim_t   req_w,
  input  dim_t   req_h,
  input  logic   req_white,
`ifdef RECT_FILL_OUTLINE_EN
  input  logic   req_outline,
`endif
  output coord_t x,
  output coord_t y,
  output logic   white,
  output logic   wr_en,
  output logic   busy,
  output logic   done
);

  rect_state_t r_state;
  rect_state_t w_state_nxt;

  coord_t r_req_x;
  coord_t r_req_y;
  dim_t   r_req_w;
  dim_t   r_req_h;
  logic   r_white;
  coord_t r_x;
  coord_t r_y;
  coord_t r_x_lo;
  coord_t r_x_hi;
  coord_t r_y_hi;

  ext_t w_x_lo;
  ext_t w_x_hi;
  ext_t w_y_lo;
  ext_t w_y_hi;
  logic w_empty;
  logic w_last;
  logic w_draw;
  logic w_accept;

  rect_clip u_clip (
    .i_x     (r_req_x),
    .i_y     (r_req_y),
    .i_w     (r_req_w),
    .i_h     (r_req_h),
    .o_x_lo  (w_x_lo),
    .o_x_hi  (w_x_hi),
    .o_y_lo  (w_y_lo),
    .o_y_hi  (w_y_hi),
    .o_empty (w_empty)
  );

  assign w_last   = (r_x == r_x_hi) && (r_y == r_y_hi);
  assign w_accept = req_valid && (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    w_draw      = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_state_nxt = CLIP;
      end
      CLIP: w_state_nxt = w_empty ? DONE : DRAW;
      DRAW: begin
        w_draw = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef RECT_FILL_OUTLINE_EN
  logic r_outline;
  logic w_on_edge;
  ext_t w_xe;
  ext_t w_ye;
  ext_t w_rx;
  ext_t w_ry;

  always_comb begin
    w_xe = sx(r_x);
    w_ye = sx(r_y);
    w_rx = sx(r_req_x);
    w_ry = sx(r_req_y);
    w_on_edge = (w_xe == w_rx) ||
                (w_xe == w_rx + zx(r_req_w) - ext_t'(1)) ||
                (w_ye == w_ry) ||
                (w_ye == w_ry + zx(r_req_h) - ext_t'(1));
  end

  always_ff @(posedge clk) begin
    if (reset)         r_outline <= 1'b0;
    else if (w_accept) r_outline <= req_outline;
  end

  assign wr_en = w_draw && (!r_outline || w_on_edge);
`else
  assign wr_en = w_draw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req_x <= '0;
      r_req_y <= '0;
      r_req_w <= '0;
      r_req_h <= '0;
      r_white <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_x_lo  <= '0;
      r_x_hi  <= '0;
      r_y_hi  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_req_x <= req_x;
        r_req_y <= req_y;
        r_req_w <= req_w;
        r_req_h <= req_h;
        r_white <= req_white;
      end
      if (r_state == CLIP) begin
        // Non-empty bounds always fit in COORD_W bits.
        r_x_lo <= w_x_lo[COORD_W-1:0];
        r_x_hi <= w_x_hi[COORD_W-1:0];
        r_y_hi <= w_y_hi[COORD_W-1:0];
        if (!w_empty) begin
          r_x <= w_x_lo[COORD_W-1:0];
          r_y <= w_y_lo[COORD_W-1:0];
        end
      end
      // Last pixel holds x/y so they never leave the screen.
      if ((r_state == DRAW) && !w_last) begin
        if (r_x == r_x_hi) begin
          r_x <= r_x_lo;
          r_y <= r_y + coord_t'(1);
        end else begin
          r_x <= r_x + coord_t'(1);
        end
      end
    end
  end

  assign x     = r_x;
  assign y     = r_y;
  assign white = r_white;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Randomized + directed bench for rect_fill_engine against a
// pixel-list reference model.
module tb_rect_fill_engine;
  import rect_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   req_valid;
  logic   req_ready;
  coord_t req_x;
  coord_t req_y;
  dim_t   req_w;
  dim_t   req_h;
  logic   req_white;
`ifdef RECT_FILL_OUTLINE_EN
  logic   req_outline;
`endif
  coord_t x;
  coord_t y;
  logic   white;
  logic   wr_en;
  logic   busy;
  logic   done;

  rect_fill_engine dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_w       (req_w),
    .req_h       (req_h),
    .req_white   (req_white),
`ifdef RECT_FILL_OUTLINE_EN
    .req_outline (req_outline),
`endif
    .x           (x),
    .y           (y),
    .white       (white),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int qx[$];
  int qy[$];

  task automatic check(string tag, logic signed [63:0] obs,
                       logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Expected writes: every on-screen pixel of the unclipped rectangle,
  // row-major; outline keeps only the perimeter but not the timing.
  task automatic model(int rx, int ry, int rw, int rh, bit ol,
                       output int n_draw);
    n_draw = 0;
    qx.delete();
    qy.delete();
    for (int yy = ry; yy < ry + rh; yy++)
      for (int xx = rx; xx < rx + rw; xx++)
        if (xx >= 0 && xx < SCREEN_W && yy >= 0 && yy < SCREEN_H) begin
          n_draw++;
          if (!ol || xx == rx || xx == rx + rw - 1 ||
              yy == ry || yy == ry + rh - 1) begin
            qx.push_back(xx);
            qy.push_back(yy);
          end
        end
  endtask

  task automatic send(string tag, int rx, int ry, int rw, int rh,
                      bit wh, bit ol);
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = coord_t'(rx);
    req_y     = coord_t'(ry);
    req_w     = dim_t'(rw);
    req_h     = dim_t'(rh);
    req_white = wh;
`ifdef RECT_FILL_OUTLINE_EN
    req_outline = ol;
`endif
    check({tag, ".ready"}, req_ready, 1);
    check({tag, ".idle_busy"}, busy, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_x     = coord_t'($urandom);
    req_y     = coord_t'($urandom);
    req_w     = dim_t'($urandom);
    req_h     = dim_t'($urandom);
    req_white = ~wh;
`ifdef RECT_FILL_OUTLINE_EN
    req_outline = ~ol;
`endif
  endtask

  task automatic run(string tag, int rx, int ry, int rw, int rh,
                     bit wh, bit ol);
    int n_draw;
    int k;
    int busy_cnt;
    int ex;
    int ey;
    bit seen;
    model(rx, ry, rw, rh, ol, n_draw);
    send(tag, rx, ry, rw, rh, wh, ol);
    seen     = 1'b0;
    busy_cnt = 0;
    for (k = 1; k <= n_draw + 10 && !seen; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (wr_en) begin
        if (qx.size() == 0) begin
          check({tag, ".extra_wr"}, 1, 0);
        end else begin
          ex = qx.pop_front();
          ey = qy.pop_front();
          check({tag, ".wr_x"}, x, ex);
          check({tag, ".wr_y"}, y, ey);
          check({tag, ".white"}, white, wh);
        end
      end
      if (done) begin
        seen = 1'b1;
        check({tag, ".done_cyc"}, k, n_draw + 2);
      end
    end
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".missing_wr"}, qx.size(), 0);
    check({tag, ".busy_cyc"}, busy_cnt, n_draw + 2);
    @(negedge clk);
    check({tag, ".ready_after"}, req_ready, 1);
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int cnt;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_w     = '0;
    req_h     = '0;
    req_white = 1'b0;
`ifdef RECT_FILL_OUTLINE_EN
    req_outline = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", req_ready, 1);
    check("rst.wr_en", wr_en, 0);
    check("rst.done", done, 0);
    check("rst.busy", busy, 0);
    check("rst.x", x, 0);
    check("rst.y", y, 0);
    check("rst.white", white, 0);
    reset = 1'b0;

    run("basic", 10, 20, 3, 2, 1'b1, 1'b0);
    run("neg", -5, -3, 8, 5, 1'b1, 1'b0);
    run("corner", 636, 478, 10, 10, 1'b0, 1'b0);
    run("offscr", 700, 10, 4, 4, 1'b1, 1'b0);
    run("w0", 5, 5, 0, 7, 1'b1, 1'b0);
    run("h0", 5, 5, 7, 0, 1'b1, 1'b0);
    run("far_neg", -1024, -1024, 1023, 1023, 1'b1, 1'b0);
    run("wide_neg", -1000, 0, 1023, 5, 1'b1, 1'b0);
    run("br", 600, 440, 100, 100, 1'b1, 1'b0);

    send("abort", 0, 0, 100, 100, 1'b1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 300 && cnt < 50; k++) begin
      @(negedge clk);
      if (wr_en) cnt++;
    end
    check("abort.50wr", cnt, 50);
    reset = 1'b1;
    @(negedge clk);
    check("abort.wr_en", wr_en, 0);
    check("abort.ready", req_ready, 1);
    check("abort.done", done, 0);
    check("abort.busy", busy, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort.no_done", done, 0);
    end
    run("one", 1, 1, 1, 1, 1'b1, 1'b0);

`ifdef RECT_FILL_OUTLINE_EN
    run("outline", 2, 2, 4, 3, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      int  rx;
      int  ry;
      int  rw;
      int  rh;
      bit  ol;
      rx = int'($urandom_range(0, 820)) - 100;
      ry = int'($urandom_range(0, 660)) - 100;
      rw = int'($urandom_range(0, 24));
      rh = int'($urandom_range(0, 24));
      if ($urandom_range(0, 7) == 0) rw = 0;
      ol = 1'b0;
`ifdef RECT_FILL_OUTLINE_EN
      ol = 1'($urandom_range(0, 1));
`endif
      run("rand", rx, ry, rw, rh, 1'($urandom_range(0, 1)), ol);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
